lsu_req_ctrl: RTL and testbench

Memory-stage request controller sitting directly upstream of the LSU. It accepts one load or store per transaction from the execute stage and drives the LSU's AXI-lite-style channels: read address/data, and write address/data/response. It performs store lane alignment and byte-strobe generation, and holds `mrtypeM` stable for the LSU's load extension. It returns load data or store completion to writeback with a single-entry response buffer.

---
 rtl/lsu_req_ctrl.sv | 174 +++++++++++++++++
 tb/tb_lsu_req_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_req_ctrl.sv
// rtl/lsu_req_ctrl.sv - single-outstanding load/store request controller in front of the LSU
module lsu_req_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_mtype,
  output logic [31:0] araddr,
  output logic [2:0]  mrtypeM,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic        rresp,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] awaddr,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bresp,
  input  logic        bvalid,
  output logic        bready,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR, WR_RESP, RESP} state_t;

  state_t      state_q;
  logic        aw_done_q;
  logic        w_done_q;
  logic        misaligned_d;
  logic [31:0] wdata_d;
  logic [3:0]  wstrb_d;
  logic        aw_done_d;
  logic        w_done_d;

  // Alignment check, store lane shift and byte strobes, all from the incoming request
  always_comb begin
    misaligned_d = 1'b0;
    wstrb_d      = 4'b1111;
    wdata_d      = req_wdata << {req_addr[1:0], 3'b000};
    case (req_mtype)
      3'd0, 3'd3: begin
        wstrb_d = 4'b0001 << req_addr[1:0];
      end
      3'd1, 3'd4: begin
        misaligned_d = req_addr[0];
        wstrb_d      = 4'b0011 << req_addr[1:0];
      end
      3'd2: begin
        misaligned_d = (req_addr[1:0] != 2'b00);
      end
      default: begin
        misaligned_d = 1'b1;
      end
    endcase
  end

  // Write channel completion: a flag set earlier or a handshake this cycle both count
  always_comb begin
    aw_done_d = aw_done_q | (awvalid & awready);
    w_done_d  = w_done_q | (wvalid & wready);
  end

  // Transaction FSM; every bus and response output is a register updated here
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      req_ready  <= 1'b1;
      araddr     <= 32'd0;
      mrtypeM    <= 3'd0;
      arvalid    <= 1'b0;
      rready     <= 1'b0;
      awaddr     <= 32'd0;
      awvalid    <= 1'b0;
      wdata      <= 32'd0;
      wstrb      <= 4'd0;
      wvalid     <= 1'b0;
      bready     <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            req_ready  <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
            if (misaligned_d) begin
              resp_err   <= 1'b1;
              resp_valid <= 1'b1;
              state_q    <= RESP;
            end else if (req_wen) begin
              awaddr  <= req_addr;
              wdata   <= wdata_d;
              wstrb   <= wstrb_d;
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
              state_q <= WR;
            end else begin
              araddr  <= req_addr;
              mrtypeM <= req_mtype;
              arvalid <= 1'b1;
              state_q <= RD_ADDR;
            end
          end
        end
        RD_ADDR: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state_q <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (rvalid) begin
            rready     <= 1'b0;
            mrtypeM    <= 3'd0;
            resp_rdata <= rdata;
            resp_err   <= rresp;
            resp_valid <= 1'b1;
            state_q    <= RESP;
          end
        end
        WR: begin
          if (awvalid && awready) awvalid <= 1'b0;
          if (wvalid && wready) wvalid <= 1'b0;
          if (aw_done_d && w_done_d) begin
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            bready    <= 1'b1;
            state_q   <= WR_RESP;
          end else begin
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
          end
        end
        WR_RESP: begin
          if (bvalid) begin
            bready     <= 1'b0;
            resp_err   <= bresp;
            resp_rdata <= 32'd0;
            resp_valid <= 1'b1;
            state_q    <= RESP;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state_q    <= IDLE;
          end
        end
        default: begin
          state_q   <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_req_ctrl.sv
// tb/tb_lsu_req_ctrl.sv - scoreboard bench for lsu_req_ctrl with directed load/store vectors
module tb_lsu_req_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wen = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [2:0]  req_mtype = 3'd0;
  logic [31:0] araddr;
  logic [2:0]  mrtypeM;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [31:0] rdata = 32'd0;
  logic        rresp = 1'b0;
  logic        rvalid = 1'b0;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready = 1'b0;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready = 1'b0;
  logic        bresp = 1'b0;
  logic        bvalid = 1'b0;
  logic        bready;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [32:0] sb_q[$];
  logic [32:0] exp_e;

  lsu_req_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_mtype(req_mtype),
    .araddr(araddr), .mrtypeM(mrtypeM), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Response monitor: pops the scoreboard on every writeback handshake
  always @(negedge clk) begin
    if (rst && resp_valid && resp_ready) begin
      if (sb_q.size() == 0) begin
        chk("resp_unexpected", 32'(resp_valid), 32'd0);
      end else begin
        exp_e = sb_q.pop_front();
        chk("resp_rdata", resp_rdata, exp_e[31:0]);
        chk("resp_err", 32'(resp_err), 32'(exp_e[32]));
      end
    end
  end

  task automatic start_point();
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("idle_wait", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic drive_req(input logic wen, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [2:0] mt);
    req_valid = 1'b1; req_wen = wen; req_addr = addr; req_wdata = wd; req_mtype = mt;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic do_load(input logic [31:0] addr, input logic [2:0] mt, input logic [31:0] rd,
                         input logic rr, input int nstall);
    start_point();
    sb_q.push_back({rr, rd});
    resp_ready = (nstall == 0);
    arready = 1'b1;
    drive_req(1'b0, addr, 32'hFFFF_FFFF, mt);
    @(negedge clk);
    chk("ld_arvalid_t1", 32'(arvalid), 32'd1);
    chk("ld_araddr", araddr, addr);
    chk("ld_mrtype_t1", 32'(mrtypeM), 32'(mt));
    chk("ld_req_ready_busy", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    arready = 1'b0; rvalid = 1'b1; rdata = rd; rresp = rr;
    @(negedge clk);
    chk("ld_rready_t2", 32'(rready), 32'd1);
    chk("ld_arvalid_drop", 32'(arvalid), 32'd0);
    chk("ld_mrtype_t2", 32'(mrtypeM), 32'(mt));
    @(posedge clk); #1;
    rvalid = 1'b0; rdata = 32'd0; rresp = 1'b0;
    @(negedge clk);
    chk("ld_resp_valid_t3", 32'(resp_valid), 32'd1);
    for (int i = 0; i < nstall; i++) begin
      chk("bp_resp_valid", 32'(resp_valid), 32'd1);
      chk("bp_resp_rdata", resp_rdata, rd);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      @(posedge clk); #1;
      if (i == nstall - 1) resp_ready = 1'b1;
      @(negedge clk);
    end
    @(posedge clk); #1;
    @(negedge clk);
    chk("ld_resp_valid_drop", 32'(resp_valid), 32'd0);
    chk("ld_req_ready_back", 32'(req_ready), 32'd1);
  endtask

  task automatic do_store(input logic [31:0] addr, input logic [31:0] wd, input logic [2:0] mt,
                          input logic [31:0] exp_wd, input logic [3:0] exp_strb, input logic br);
    start_point();
    sb_q.push_back({br, 32'd0});
    resp_ready = 1'b1; awready = 1'b1; wready = 1'b1;
    drive_req(1'b1, addr, wd, mt);
    @(negedge clk);
    chk("st_awvalid_t1", 32'(awvalid), 32'd1);
    chk("st_wvalid_t1", 32'(wvalid), 32'd1);
    chk("st_awaddr", awaddr, addr);
    chk("st_wdata", wdata, exp_wd);
    chk("st_wstrb", 32'(wstrb), 32'(exp_strb));
    @(posedge clk); #1;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b1; bresp = br;
    @(negedge clk);
    chk("st_bready_t2", 32'(bready), 32'd1);
    chk("st_awvalid_drop", 32'(awvalid), 32'd0);
    chk("st_wvalid_drop", 32'(wvalid), 32'd0);
    @(posedge clk); #1;
    bvalid = 1'b0; bresp = 1'b0;
    @(negedge clk);
    chk("st_resp_valid_t3", 32'(resp_valid), 32'd1);
  endtask

  task automatic do_misaligned(input logic wen, input logic [31:0] addr, input logic [2:0] mt);
    start_point();
    sb_q.push_back({1'b1, 32'd0});
    resp_ready = 1'b1;
    drive_req(wen, addr, 32'h5555_5555, mt);
    @(negedge clk);
    chk("mis_resp_valid_t1", 32'(resp_valid), 32'd1);
    chk("mis_arvalid", 32'(arvalid), 32'd0);
    chk("mis_awvalid", 32'(awvalid), 32'd0);
    chk("mis_wvalid", 32'(wvalid), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("mis_arvalid_after", 32'(arvalid), 32'd0);
    chk("mis_resp_valid_drop", 32'(resp_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_arvalid", 32'(arvalid), 32'd0);
    chk("rst_awvalid", 32'(awvalid), 32'd0);
    chk("rst_wstrb", 32'(wstrb), 32'd0);
    rst = 1'b1;

    do_load(32'h8000_0010, 3'd2, 32'hDEAD_BEEF, 1'b0, 0);
    do_store(32'h8000_0003, 32'h0000_00A5, 3'd0, 32'hA500_0000, 4'b1000, 1'b0);
    do_store(32'h8000_0102, 32'h0000_1234, 3'd1, 32'h1234_0000, 4'b1100, 1'b0);
    do_store(32'h8000_0021, 32'hFFFF_FF5A, 3'd0, 32'hFFFF_5A00, 4'b0010, 1'b0);
    do_store(32'h8000_0020, 32'hCAFE_F00D, 3'd2, 32'hCAFE_F00D, 4'b1111, 1'b1);
    do_load(32'h8000_0044, 3'd2, 32'h1122_3344, 1'b1, 0);
    do_load(32'h8000_0042, 3'd4, 32'h0000_BEEF, 1'b0, 0);
    do_misaligned(1'b0, 32'h8000_0001, 3'd1);
    do_misaligned(1'b0, 32'h8000_0002, 3'd2);
    do_misaligned(1'b1, 32'h8000_0003, 3'd4);
    do_misaligned(1'b0, 32'h8000_0000, 3'd5);
    do_load(32'h8000_0007, 3'd0, 32'h0000_00AB, 1'b0, 4);

    // Split write handshake: address accepted at once, data held off until T+5
    start_point();
    sb_q.push_back({1'b1, 32'd0});
    awready = 1'b1; wready = 1'b0;
    drive_req(1'b1, 32'h8000_0030, 32'h0BAD_CAFE, 3'd2);
    @(negedge clk);
    chk("split_awvalid_t1", 32'(awvalid), 32'd1);
    chk("split_wvalid_t1", 32'(wvalid), 32'd1);
    for (int k = 2; k <= 5; k++) begin
      @(posedge clk); #1;
      awready = 1'b0;
      if (k == 5) wready = 1'b1;
      @(negedge clk);
      chk("split_awvalid_low", 32'(awvalid), 32'd0);
      chk("split_wvalid_hold", 32'(wvalid), 32'd1);
      chk("split_wdata_hold", wdata, 32'h0BAD_CAFE);
      chk("split_bready_low", 32'(bready), 32'd0);
    end
    @(posedge clk); #1;
    wready = 1'b0; bvalid = 1'b1; bresp = 1'b1;
    @(negedge clk);
    chk("split_bready_t6", 32'(bready), 32'd1);
    chk("split_wvalid_drop", 32'(wvalid), 32'd0);
    @(posedge clk); #1;
    bvalid = 1'b0; bresp = 1'b0;
    @(negedge clk);
    chk("split_resp_valid_t7", 32'(resp_valid), 32'd1);

    // Reset while waiting for read data abandons the load
    start_point();
    arready = 1'b1;
    drive_req(1'b0, 32'h8000_0050, 32'd0, 3'd2);
    @(posedge clk); #1;
    arready = 1'b0;
    @(negedge clk);
    chk("rstmid_in_rd_data", 32'(rready), 32'd1);
    rst = 1'b0;
    #1;
    chk("rstmid_rready", 32'(rready), 32'd0);
    chk("rstmid_req_ready", 32'(req_ready), 32'd1);
    chk("rstmid_araddr", araddr, 32'd0);
    chk("rstmid_awaddr", awaddr, 32'd0);
    chk("rstmid_wdata", wdata, 32'd0);
    chk("rstmid_wstrb", 32'(wstrb), 32'd0);
    chk("rstmid_mrtype", 32'(mrtypeM), 32'd0);
    chk("rstmid_resp_err", 32'(resp_err), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("rstmid_after_req_ready", 32'(req_ready), 32'd1);
      chk("rstmid_after_resp_valid", 32'(resp_valid), 32'd0);
    end

    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
